// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch with in-flight hold, redirect discard and a
//            stall skid buffer feeding the IF/ID register.
//            Optional macro FETCH_MISALIGN_CHECK_EN adds misaligned-target
//            detection and the misalignD output.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int                       DATA_BUS_BITS = 32,
    parameter logic [DATA_BUS_BITS-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stallF,
    input  logic                     branchE,
    input  logic                     jumpE,
    input  logic                     branchTaken,
    input  logic [DATA_BUS_BITS-1:0] PCTarget,
    output logic                     imem_req,
    output logic [DATA_BUS_BITS-1:0] imem_addr,
    input  logic                     imem_ready,
    input  logic [31:0]              imem_rdata,
    output logic [31:0]              instrD,
    output logic [DATA_BUS_BITS-1:0] PCD,
    output logic [DATA_BUS_BITS-1:0] PCPlus4D,
    output logic                     validD
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic                     misalignD
`endif
);

    localparam logic [1:0] c_st_fetch   = 2'd0;
    localparam logic [1:0] c_st_discard = 2'd1;
    localparam logic [1:0] c_st_hold    = 2'd2;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam logic [1:0] c_st_idle    = 2'd3;
    localparam logic [31:0] c_nop       = 32'h0000_0013;
`endif
    localparam logic [DATA_BUS_BITS-1:0] c_four       = DATA_BUS_BITS'(4);
    localparam logic [DATA_BUS_BITS-1:0] c_align_mask = DATA_BUS_BITS'(3);

    logic [1:0]               r_state;
    logic [DATA_BUS_BITS-1:0] r_pcf;
    logic [DATA_BUS_BITS-1:0] r_fetch_addr;
    logic                     r_inflight;
    logic [31:0]              r_skid_instr;
    logic [DATA_BUS_BITS-1:0] r_skid_pc;
    logic [31:0]              r_instr_d;
    logic [DATA_BUS_BITS-1:0] r_pc_d;
    logic [DATA_BUS_BITS-1:0] r_pcplus4_d;
    logic                     r_valid_d;

    logic                     w_redirect;
    logic                     w_req;
    logic                     w_hs;
    logic [DATA_BUS_BITS-1:0] w_addr;
    logic [DATA_BUS_BITS-1:0] w_target;

    assign w_redirect = jumpE | (branchE & branchTaken);
    // An in-flight request must stay asserted regardless of stall or redirect.
    assign w_req      = ~rst & (r_inflight |
                        ((r_state == c_st_fetch) & ~stallF & ~w_redirect));
    assign w_addr     = r_inflight ? r_fetch_addr : r_pcf;
    assign w_hs       = w_req & imem_ready;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic w_misalign;
    logic r_misalign_d;
    assign w_target   = PCTarget;
    assign w_misalign = |PCTarget[1:0];
    assign misalignD  = r_misalign_d;
`else
    assign w_target   = PCTarget & ~c_align_mask;
`endif

    assign imem_req  = w_req;
    assign imem_addr = w_addr;
    assign instrD    = r_instr_d;
    assign PCD       = r_pc_d;
    assign PCPlus4D  = r_pcplus4_d;
    assign validD    = r_valid_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_st_fetch;
            r_pcf        <= RESET_PC;
            r_fetch_addr <= '0;
            r_inflight   <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
            r_instr_d    <= '0;
            r_pc_d       <= '0;
            r_pcplus4_d  <= '0;
            r_valid_d    <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            r_misalign_d <= 1'b0;
`endif
        end else if (w_redirect) begin
            r_pcf      <= w_target;
            r_valid_d  <= 1'b0;
            r_inflight <= r_inflight & ~imem_ready;
            r_state    <= (r_inflight & ~imem_ready) ? c_st_discard : c_st_fetch;
`ifdef FETCH_MISALIGN_CHECK_EN
            r_misalign_d <= 1'b0;
            if (w_misalign) begin
                r_state      <= c_st_idle;
                r_instr_d    <= c_nop;
                r_pc_d       <= w_target;
                r_pcplus4_d  <= w_target + c_four;
                r_valid_d    <= 1'b1;
                r_misalign_d <= 1'b1;
            end
`endif
        end else begin
            case (r_state)
                c_st_fetch: begin
                    if (w_hs) begin
                        r_inflight <= 1'b0;
                        if (stallF) begin
                            r_skid_instr <= imem_rdata;
                            r_skid_pc    <= w_addr;
                            r_state      <= c_st_hold;
                        end else begin
                            r_instr_d   <= imem_rdata;
                            r_pc_d      <= w_addr;
                            r_pcplus4_d <= w_addr + c_four;
                            r_valid_d   <= 1'b1;
                            r_pcf       <= w_addr + c_four;
                        end
                    end else begin
                        if (w_req) begin
                            r_inflight   <= 1'b1;
                            r_fetch_addr <= w_addr;
                        end
                        if (!stallF) begin
                            r_valid_d <= 1'b0;
                        end
                    end
                end
                c_st_hold: begin
                    if (!stallF) begin
                        r_instr_d   <= r_skid_instr;
                        r_pc_d      <= r_skid_pc;
                        r_pcplus4_d <= r_skid_pc + c_four;
                        r_valid_d   <= 1'b1;
                        r_pcf       <= r_skid_pc + c_four;
                        r_state     <= c_st_fetch;
                    end
                end
                c_st_discard: begin
                    r_valid_d <= 1'b0;
                    if (w_hs) begin
                        r_inflight <= 1'b0;
                        r_state    <= c_st_fetch;
                    end
                end
`ifdef FETCH_MISALIGN_CHECK_EN
                c_st_idle: begin
                    // Parked after a misaligned target; only a redirect leaves.
                    r_valid_d    <= 1'b0;
                    r_misalign_d <= 1'b0;
                    if (w_hs) begin
                        r_inflight <= 1'b0;
                    end
                end
`endif
                default: r_state <= c_st_fetch;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 0, PC value loaded on reset; DataBusBits-wide.
REQ-002 clk  in  1  sole clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 stallF  in  1  hazard-unit stall; holds PC and IF/ID.
REQ-005 branchE, jumpE  in  1 each  execute-stage instruction is conditional branch / jump.
REQ-006 branchTaken  in  1  branch-unit outcome; meaningful only with branchE.
REQ-007 PCTarget  in  DataBusBits  redirect target from branch unit.
REQ-008 imem_req  out  1  fetch request valid.
REQ-009 imem_addr  out  DataBusBits  fetch byte address.
REQ-010 imem_ready  in  1  memory accepts request; imem_rdata valid in the same cycle.
REQ-011 imem_rdata  in  32  fetched instruction.
REQ-012 instrD  out  32; PCD, PCPlus4D  out  DataBusBits; validD  out  1  IF/ID register.

Function
REQ-013 redirect = jumpE | (branchE & branchTaken); handshake = imem_req & imem_ready.
REQ-014 Priority: redirect > stallF > normal advance.
REQ-015 FSM states FETCH, DISCARD, HOLD; reset state FETCH.
REQ-016 In-flight rule: once imem_req is asserted without imem_ready, imem_req and imem_addr SHALL hold stable until handshake; in-flight address is registered as fetchAddr.
REQ-017 imem_addr = fetchAddr when in flight, else PCF.
REQ-018 FETCH, no redirect, no stall: imem_req=1; on handshake, IF/ID <= {imem_rdata, PCF, PCF+4, valid=1} and PCF <= PCF+4 (modulo 2^DataBusBits); no handshake -> validD <= 0.
REQ-019 FETCH, stallF, no redirect: new request not launched; in-flight request held; IF/ID holds; handshake during stall -> data and PC into skid buffer, go HOLD.
REQ-020 HOLD: imem_req=0; on stallF deassert, skid -> IF/ID with validD=1, PCF <= skid PC+4, go FETCH; single-cycle latency.
REQ-021 Redirect any state: PCF <= PCTarget, validD <= 0 next cycle, skid dropped; if request in flight and not completing this cycle -> DISCARD, else FETCH.
REQ-022 DISCARD: held request completes, rdata dropped, validD=0, then FETCH from PCF; further redirect in DISCARD updates PCF, stays DISCARD.
REQ-023 Redirect with stallF: redirect wins; PCF updates, IF/ID flushed.
REQ-024 Back-to-back handshakes SHALL sustain one instruction per cycle.

Reset
REQ-025 rst async: PCF=RESET_PC, state FETCH, in-flight and skid cleared, validD=0, instrD=0, PCD=0, PCPlus4D=0, imem_req=0 while rst asserted.
REQ-026 rst mid-transaction abandons it; first request after release uses RESET_PC.

Configuration
REQ-027 Macro FETCH_MISALIGN_CHECK_EN defined: extra port misalignD out 1; redirect with PCTarget[1:0]!=0 loads PCF, issues no request, writes one IF/ID entry {instrD=32'h00000013, validD=1, misalignD=1}, then idles (imem_req=0) until next redirect; misalignD resets to 0.
REQ-028 Macro undefined: no misalignD port; PCTarget[1:0] forced to 2'b00 on redirect.

Verification
REQ-029 RESET_PC=0x1000, imem_ready=1 constant -> addrs 0x1000,0x1004,0x1008 consecutive cycles; validD=1 from second cycle.
REQ-030 imem_ready low 3 cycles at 0x1004 -> imem_addr stays 0x1004, validD=0 for 3 cycles, then PCD=0x1004.
REQ-031 Redirect branchE=1, branchTaken=1, PCTarget=0x2000 while 0x1008 in flight with ready=0 -> DISCARD, 0x1008 data dropped, next request 0x2000, no validD for 0x1008.
REQ-032 stallF high 2 cycles with handshake in cycle 1 -> HOLD, imem_req=0, IF/ID unchanged; release -> skid instruction appears next cycle, following fetch at PC+4.
REQ-033 jumpE=1 with stallF=1, PCTarget=0x3000 -> PCF=0x3000, validD=0 next cycle.
REQ-034 With FETCH_MISALIGN_CHECK_EN, PCTarget=0x2002 -> one entry misalignD=1, instrD=0x00000013, then imem_req=0 until redirect; without macro -> fetch from 0x2000.
